// File: rtl/flag_reg_bank.sv
// flag_reg_bank: per-core Z/N/C condition-flag registers with sticky
// accumulation, per-channel clear, a single-level save/restore shadow and
// reduced allZero/anyZero outputs for the multicore barrier logic.
// Optional per-channel zero-streak counters are built only when the macro
// ZERO_STREAK_EN is defined; otherwise zeroStreak is tied to 0.
module flag_reg_bank #(
  parameter int WIDTH  = 12,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         writeEn,
  input  logic [NUM_CH*WIDTH-1:0]   dataIn,
  input  logic [NUM_CH-1:0]         carryIn,
  input  logic [NUM_CH-1:0]         stickyMode,
  input  logic [NUM_CH-1:0]         clearEn,
  input  logic                      saveEn,
  input  logic                      restoreEn,
  output logic [NUM_CH-1:0]         zeroFlag,
  output logic [NUM_CH-1:0]         negFlag,
  output logic [NUM_CH-1:0]         carryFlag,
  output logic                      allZero,
  output logic                      anyZero,
  output logic                      shadowValid,
  output logic [NUM_CH*CNT_W-1:0]   zeroStreak
);

  // Live flags
  logic [NUM_CH-1:0] zero_q, zero_d;
  logic [NUM_CH-1:0] neg_q, neg_d;
  logic [NUM_CH-1:0] carry_q, carry_d;

  // Shadow copy of the live flags
  logic [NUM_CH-1:0] sh_zero_q, sh_zero_d;
  logic [NUM_CH-1:0] sh_neg_q, sh_neg_d;
  logic [NUM_CH-1:0] sh_carry_q, sh_carry_d;
  logic              shadow_valid_q, shadow_valid_d;

  // Flag values computed from this cycle's ALU result
  logic [NUM_CH-1:0] calc_zero;
  logic [NUM_CH-1:0] calc_neg;
  logic              restore_act;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_calc
      assign calc_zero[gi] = (dataIn[gi*WIDTH +: WIDTH] == '0);
      assign calc_neg[gi]  = dataIn[gi*WIDTH + WIDTH - 1];
    end
  endgenerate

  // A restore request only counts when there is a saved context to consume.
  assign restore_act = restoreEn & shadow_valid_q;

  // Live-flag next state: clear beats restore beats write beats hold.
  always_comb begin
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clearEn[i]) begin
        zero_d[i]  = 1'b0;
        neg_d[i]   = 1'b0;
        carry_d[i] = 1'b0;
      end else if (restore_act) begin
        zero_d[i]  = sh_zero_q[i];
        neg_d[i]   = sh_neg_q[i];
        carry_d[i] = sh_carry_q[i];
      end else if (writeEn[i]) begin
        if (stickyMode[i]) begin
          zero_d[i]  = zero_q[i]  | calc_zero[i];
          neg_d[i]   = neg_q[i]   | calc_neg[i];
          carry_d[i] = carry_q[i] | carryIn[i];
        end else begin
          zero_d[i]  = calc_zero[i];
          neg_d[i]   = calc_neg[i];
          carry_d[i] = carryIn[i];
        end
      end
    end
  end

  // Shadow next state: save captures pre-edge live flags, so a save together
  // with a restore exchanges the two sets and keeps the shadow valid.
  always_comb begin
    sh_zero_d      = sh_zero_q;
    sh_neg_d       = sh_neg_q;
    sh_carry_d     = sh_carry_q;
    shadow_valid_d = shadow_valid_q;
    if (saveEn) begin
      sh_zero_d      = zero_q;
      sh_neg_d       = neg_q;
      sh_carry_d     = carry_q;
      shadow_valid_d = 1'b1;
    end else if (restore_act) begin
      shadow_valid_d = 1'b0;
    end
  end

  // Flag and shadow registers with asynchronous reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      zero_q         <= '0;
      neg_q          <= '0;
      carry_q        <= '0;
      sh_zero_q      <= '0;
      sh_neg_q       <= '0;
      sh_carry_q     <= '0;
      shadow_valid_q <= 1'b0;
    end else begin
      zero_q         <= zero_d;
      neg_q          <= neg_d;
      carry_q        <= carry_d;
      sh_zero_q      <= sh_zero_d;
      sh_neg_q       <= sh_neg_d;
      sh_carry_q     <= sh_carry_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

  assign zeroFlag    = zero_q;
  assign negFlag     = neg_q;
  assign carryFlag   = carry_q;
  assign allZero     = &zero_q;
  assign anyZero     = |zero_q;
  assign shadowValid = shadow_valid_q;

`ifdef ZERO_STREAK_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] streak_q [NUM_CH];
  logic [CNT_W-1:0] streak_d [NUM_CH];

  // Streak counters: count consecutive zero writes, saturating; independent
  // of sticky mode and of save/restore.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      streak_d[i] = streak_q[i];
      if (clearEn[i]) begin
        streak_d[i] = '0;
      end else if (writeEn[i]) begin
        if (!calc_zero[i]) begin
          streak_d[i] = '0;
        end else if (streak_q[i] != '1) begin
          streak_d[i] = streak_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Streak counter registers with asynchronous reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        streak_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        streak_q[i] <= streak_d[i];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_streak_out
      assign zeroStreak[gi*CNT_W +: CNT_W] = streak_q[gi];
    end
  endgenerate
`else
  assign zeroStreak = '0;
`endif

endmodule
